// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared Aurora character codes, ordered-set flags and detector state types
package aurora_pkg;

    localparam int INTERMEDIATE_DATA_SIZE = 8;

    // K characters
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] K23_7 = 8'hF7;

    // D characters used inside lane-init ordered sets
    localparam logic [7:0] D21_4 = 8'h95;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D12_2 = 8'h4C;
    localparam logic [7:0] D8_7  = 8'hE8;

    // One flag per ordered set; k is bit 0, ver is bit 12
    typedef struct packed {
        logic ver;
        logic spa;
        logic sp;
        logic cc;
        logic ecp;
        logic scp;
        logic suf;
        logic snf;
        logic p;
        logic a;
        logic r;
        logic i;
        logic k;
    } ordered_sets_t;

    localparam int OS_FLAG_COUNT = $bits(ordered_sets_t);

    typedef enum logic [2:0] {
        IDLE,
        SCP1,
        ECP1,
        CC1,
        LS1,
        LS2,
        LS3
    } os_det_state_t;

    // One-hot character class
    typedef struct packed {
        logic single;
        logic start2;
        logic ls;
        logic data;
        logic unk_k;
    } char_class_t;

endpackage

// File: rtl/aurora_char_classify.sv
// rtl/aurora_char_classify.sv - combinational classifier of one decoded character
//
// Ports:
//   char_data   in   decoded character
//   char_is_k   in   1 = control character
//   cls         out  one-hot class (single set, 2-byte start, LS start, data, unknown K)
//   single_os   out  flags pulsed by this character on its own (also K|I for the LS start)
//   start_state out  FSM state entered for a 2-byte start character
module aurora_char_classify
    import aurora_pkg::*;
(
    input  logic [7:0]    char_data,
    input  logic          char_is_k,
    output char_class_t   cls,
    output ordered_sets_t single_os,
    output os_det_state_t start_state
);

    always_comb begin
        cls         = '0;
        single_os   = '0;
        start_state = IDLE;
        if (!char_is_k) begin
            cls.data = 1'b1;
        end else begin
            case (char_data)
                K28_5: begin cls.ls = 1'b1; single_os.k = 1'b1; single_os.i = 1'b1; end
                K28_0: begin cls.single = 1'b1; single_os.r = 1'b1; single_os.i = 1'b1; end
                K28_3: begin cls.single = 1'b1; single_os.a = 1'b1; single_os.i = 1'b1; end
                K28_4: begin cls.single = 1'b1; single_os.p = 1'b1; end
                K28_6: begin cls.single = 1'b1; single_os.snf = 1'b1; end
                K28_1: begin cls.single = 1'b1; single_os.suf = 1'b1; end
                K28_2: begin cls.start2 = 1'b1; start_state = SCP1; end
                K29_7: begin cls.start2 = 1'b1; start_state = ECP1; end
                K23_7: begin cls.start2 = 1'b1; start_state = CC1; end
                default: cls.unk_k = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/aurora_os_detector.sv
// rtl/aurora_os_detector.sv - receive-side Aurora ordered-set detector
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_data_i     decoded character, rx_is_k_i K flag, rx_valid_i character present
//   os_o          one-cycle pulse per detected ordered set
//   data_o        passthrough data character, qualified by data_valid_o
//   seq_err_o     pulse: multi-byte sequence broken
//   code_err_o    pulse: unrecognised K character
// All outputs are registered (one cycle after the accepting input cycle).
module aurora_os_detector
    import aurora_pkg::*;
#(
    parameter int DATA_W = INTERMEDIATE_DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_is_k_i,
    input  logic              rx_valid_i,
    output ordered_sets_t     os_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              seq_err_o,
    output logic              code_err_o
);

    os_det_state_t state, state_n;
    logic [DATA_W-1:0] stored, stored_n;

    ordered_sets_t     os_n;
    logic [DATA_W-1:0] data_n;
    logic              dv_n, seq_n, code_n, reeval;

    char_class_t   cls;
    ordered_sets_t single_os;
    os_det_state_t start_state;

    aurora_char_classify u_classify (
        .char_data   (rx_data_i),
        .char_is_k   (rx_is_k_i),
        .cls         (cls),
        .single_os   (single_os),
        .start_state (start_state)
    );

    logic is_d;
    assign is_d = rx_valid_i && !rx_is_k_i;

    always_comb begin
        state_n  = state;
        stored_n = stored;
        os_n     = '0;
        data_n   = '0;
        dv_n     = 1'b0;
        seq_n    = 1'b0;
        code_n   = 1'b0;
        reeval   = 1'b0;

        if (rx_valid_i) begin
            case (state)
                IDLE: reeval = 1'b1;
                SCP1: if (rx_is_k_i && rx_data_i == K27_7) begin
                          os_n.scp = 1'b1; state_n = IDLE;
                      end else begin
                          seq_n = 1'b1; reeval = 1'b1;
                      end
                ECP1: if (rx_is_k_i && rx_data_i == K30_7) begin
                          os_n.ecp = 1'b1; state_n = IDLE;
                      end else begin
                          seq_n = 1'b1; reeval = 1'b1;
                      end
                CC1:  if (rx_is_k_i && rx_data_i == K23_7) begin
                          os_n.cc = 1'b1; state_n = IDLE;
                      end else begin
                          seq_n = 1'b1; reeval = 1'b1;
                      end
                // BC followed by anything but 95 is just an idle stream, not an error
                LS1:  if (is_d && rx_data_i == D21_4) begin
                          state_n = LS2;
                      end else begin
                          reeval = 1'b1;
                      end
                LS2:  if (is_d && (rx_data_i == D21_5 || rx_data_i == D12_2 || rx_data_i == D8_7)) begin
                          stored_n = rx_data_i; state_n = LS3;
                      end else begin
                          seq_n = 1'b1; reeval = 1'b1;
                      end
                LS3:  if (is_d && rx_data_i == stored) begin
                          os_n.sp  = (stored == D21_5);
                          os_n.spa = (stored == D12_2);
                          os_n.ver = (stored == D8_7);
                          stored_n = '0;
                          state_n  = IDLE;
                      end else begin
                          seq_n = 1'b1; reeval = 1'b1;
                      end
                default: state_n = IDLE;
            endcase

            // The breaking byte of an aborted sequence is treated as if seen in IDLE
            if (reeval) begin
                state_n = IDLE;
                if (cls.single) os_n = os_n | single_os;
                if (cls.start2) state_n = start_state;
                if (cls.ls) begin
                    os_n    = os_n | single_os;
                    state_n = LS1;
                end
                if (cls.data) begin
                    data_n = rx_data_i;
                    dv_n   = 1'b1;
                end
                if (cls.unk_k) code_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stored       <= '0;
            os_o         <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            seq_err_o    <= 1'b0;
            code_err_o   <= 1'b0;
        end else begin
            state        <= state_n;
            stored       <= stored_n;
            os_o         <= os_n;
            data_o       <= data_n;
            data_valid_o <= dv_n;
            seq_err_o    <= seq_n;
            code_err_o   <= code_n;
        end
    end

endmodule

// File: tb/tb_aurora_os_detector.sv
// tb/tb_aurora_os_detector.sv - directed self-checking bench for aurora_os_detector
module tb_aurora_os_detector;
    import aurora_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data_i;
    logic          rx_is_k_i;
    logic          rx_valid_i;
    ordered_sets_t os_o;
    logic [7:0]    data_o;
    logic          data_valid_o;
    logic          seq_err_o;
    logic          code_err_o;

    int tests = 0;
    int fails = 0;

    // os_o bit values: k=001 i=002 r=004 a=008 p=010 snf=020 suf=040
    // scp=080 ecp=100 cc=200 sp=400 spa=800 ver=1000
    localparam logic [12:0] O_NONE = 13'h0000;
    localparam logic [12:0] O_KI   = 13'h0003;
    localparam logic [12:0] O_RI   = 13'h0006;
    localparam logic [12:0] O_AI   = 13'h000A;
    localparam logic [12:0] O_P    = 13'h0010;
    localparam logic [12:0] O_SNF  = 13'h0020;
    localparam logic [12:0] O_SUF  = 13'h0040;
    localparam logic [12:0] O_SCP  = 13'h0080;
    localparam logic [12:0] O_ECP  = 13'h0100;
    localparam logic [12:0] O_CC   = 13'h0200;
    localparam logic [12:0] O_SP   = 13'h0400;
    localparam logic [12:0] O_SPA  = 13'h0800;
    localparam logic [12:0] O_VER  = 13'h1000;

    aurora_os_detector #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data_i),
        .rx_is_k_i    (rx_is_k_i),
        .rx_valid_i   (rx_valid_i),
        .os_o         (os_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .seq_err_o    (seq_err_o),
        .code_err_o   (code_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_outputs(input string tag, input logic [12:0] e_os, input logic [7:0] e_d,
                                 input logic e_dv, input logic e_seq, input logic e_code);
        logic [12:0] os_bits;
        os_bits = os_o;
        tests++;
        assert (os_bits === e_os) else begin
            fails++; $error("FAIL %s os_o got %h expected %h", tag, os_bits, e_os);
        end
        tests++;
        assert (data_o === e_d) else begin
            fails++; $error("FAIL %s data_o got %h expected %h", tag, data_o, e_d);
        end
        tests++;
        assert (data_valid_o === e_dv) else begin
            fails++; $error("FAIL %s data_valid_o got %b expected %b", tag, data_valid_o, e_dv);
        end
        tests++;
        assert (seq_err_o === e_seq) else begin
            fails++; $error("FAIL %s seq_err_o got %b expected %b", tag, seq_err_o, e_seq);
        end
        tests++;
        assert (code_err_o === e_code) else begin
            fails++; $error("FAIL %s code_err_o got %b expected %b", tag, code_err_o, e_code);
        end
    endtask

    // Drive one character at a negedge; outputs for it are checked at the next negedge
    task automatic step(input string tag, input logic [7:0] d, input logic k, input logic v,
                        input logic [12:0] e_os, input logic [7:0] e_d, input logic e_dv,
                        input logic e_seq, input logic e_code);
        rx_data_i  = d;
        rx_is_k_i  = k;
        rx_valid_i = v;
        @(negedge clk);
        check_outputs(tag, e_os, e_d, e_dv, e_seq, e_code);
    endtask

    task automatic idle(input string tag);
        step(tag, 8'h00, 1'b0, 1'b0, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        rx_data_i  = 8'h00;
        rx_is_k_i  = 1'b0;
        rx_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset", O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Data passthrough
        step("d11", 8'h11, 1'b0, 1'b1, O_NONE, 8'h11, 1'b1, 1'b0, 1'b0);
        step("d22", 8'h22, 1'b0, 1'b1, O_NONE, 8'h22, 1'b1, 1'b0, 1'b0);
        step("d33", 8'h33, 1'b0, 1'b1, O_NONE, 8'h33, 1'b1, 1'b0, 1'b0);
        idle("idle0");

        // Single-character sets; 1C right after BC exits LS1 without error
        step("bc", 8'hBC, 1'b1, 1'b1, O_KI, 8'h00, 1'b0, 1'b0, 1'b0);
        step("1c", 8'h1C, 1'b1, 1'b1, O_RI, 8'h00, 1'b0, 1'b0, 1'b0);
        step("7c", 8'h7C, 1'b1, 1'b1, O_AI, 8'h00, 1'b0, 1'b0, 1'b0);
        step("9c", 8'h9C, 1'b1, 1'b1, O_P,  8'h00, 1'b0, 1'b0, 1'b0);
        step("dc", 8'hDC, 1'b1, 1'b1, O_SNF, 8'h00, 1'b0, 1'b0, 1'b0);
        step("3c", 8'h3C, 1'b1, 1'b1, O_SUF, 8'h00, 1'b0, 1'b0, 1'b0);

        // Two-character sets with valid gaps inside each pair
        step("scp1", 8'h5C, 1'b1, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("scp_gap"); idle("scp_gap"); idle("scp_gap");
        step("scp2", 8'hFB, 1'b1, 1'b1, O_SCP, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ecp1", 8'hFD, 1'b1, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("ecp_gap"); idle("ecp_gap"); idle("ecp_gap");
        step("ecp2", 8'hFE, 1'b1, 1'b1, O_ECP, 8'h00, 1'b0, 1'b0, 1'b0);
        step("cc1", 8'hF7, 1'b1, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("cc_gap"); idle("cc_gap"); idle("cc_gap");
        step("cc2", 8'hF7, 1'b1, 1'b1, O_CC, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("post_cc");

        // Four-character lane-init sets
        step("spa_bc", 8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("spa_95", 8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("spa_4c", 8'h4C, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("spa_4c", 8'h4C, 1'b0, 1'b1, O_SPA,  8'h00, 1'b0, 1'b0, 1'b0);
        step("sp_bc",  8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("sp_95",  8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("sp_b5",  8'hB5, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("sp_gap");
        step("sp_b5",  8'hB5, 1'b0, 1'b1, O_SP,   8'h00, 1'b0, 1'b0, 1'b0);
        step("ver_bc", 8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("ver_95", 8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ver_e8", 8'hE8, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ver_e8", 8'hE8, 1'b0, 1'b1, O_VER,  8'h00, 1'b0, 1'b0, 1'b0);

        // Error cases
        step("bad_bc", 8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("bad_95", 8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bad_4c", 8'h4C, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bad_4d", 8'h4D, 1'b0, 1'b1, O_NONE, 8'h4D, 1'b1, 1'b1, 1'b0);
        step("bad_5c", 8'h5C, 1'b1, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bad_1c", 8'h1C, 1'b1, 1'b1, O_RI,   8'h00, 1'b0, 1'b1, 1'b0);
        step("lone_fb", 8'hFB, 1'b1, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b1);
        step("ls2_d",  8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("ls2_95", 8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ls2_77", 8'h77, 1'b0, 1'b1, O_NONE, 8'h77, 1'b1, 1'b1, 1'b0);

        // Reset mid-sequence
        step("rst_bc", 8'hBC, 1'b1, 1'b1, O_KI,   8'h00, 1'b0, 1'b0, 1'b0);
        step("rst_95", 8'h95, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rst_b5", 8'hB5, 1'b0, 1'b1, O_NONE, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle("rst_cyc");
        rst = 1'b0;
        step("post_rst_b5", 8'hB5, 1'b0, 1'b1, O_NONE, 8'hB5, 1'b1, 1'b0, 1'b0);
        idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aurora_os_detector.md
Name: aurora_os_detector

Overview:
- Receive-side counterpart to the ordered-set generator.
- Consumes the byte-serial intermediate 8-bit stream (data + K flag) after 10b/8b decoding. It recognises Aurora ordered sets of 1, 2 and 4 characters and reports each as a one-cycle pulse on an ordered_sets_t vector.
- Plain data characters pass through to the lane logic. Malformed multi-byte sequences and unknown K characters are flagged.

Parameters:
- DATA_W, INTERMEDIATE_DATA_SIZE (8): width of the character bus. Only 8 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data_i  in  8  decoded character
- rx_is_k_i  in  1  1 = control (K) character
- rx_valid_i  in  1  character present this cycle
- os_o  out  13  ordered_sets_t; one-cycle pulse per detected set
- data_o  out  8  passthrough data character
- data_valid_o  out  1  data_o qualifier
- seq_err_o  out  1  pulse: multi-byte sequence broken
- code_err_o  out  1  pulse: unrecognised K character

Behaviour:
- Character codes (package constants):
  - K28.5 BC, K28.0 1C, K28.3 7C, K28.4 9C
  - K28.6 DC (SNF), K28.1 3C (SUF)
  - K28.2 5C, K27.7 FB, K29.7 FD, K30.7 FE, K23.7 F7
  - D21.4 95, D21.5 B5, D12.2 4C, D8.7 E8
- Single-character sets, flagged on the byte itself:
  - BC -> K and I; 1C -> R and I; 7C -> A and I
  - 9C -> P; DC -> SNF; 3C -> SUF
- Two-character sets, flagged on the 2nd byte:
  - 5C FB -> SCP
  - FD FE -> ECP
  - F7 F7 -> CC
- Four-character sets, flagged on the 4th byte:
  - BC 95 B5 B5 -> SP
  - BC 95 4C 4C -> SPA
  - BC 95 E8 E8 -> VER
  - The leading BC also pulses K and I in its own cycle.
- All outputs are registered. os_o, data_o/data_valid_o, seq_err_o and code_err_o appear 1 cycle after the accepting rx_valid_i cycle.
- Reset value of every output: 0.
- FSM states: IDLE, SCP1, ECP1, CC1, LS1, LS2, LS3.
  - The FSM advances only on rx_valid_i=1. With rx_valid_i=0, state and stored byte are held indefinitely; there is no timeout.
- IDLE transitions:
  - 5C -> SCP1; FD -> ECP1; F7 -> CC1; BC -> LS1.
  - Other listed K codes: pulse their flag, stay in IDLE.
  - Unlisted K (including FB or FE alone): code_err_o, stay in IDLE.
  - D character: data_o/data_valid_o, stay in IDLE.
- SCP1 / ECP1 / CC1:
  - Expected K byte: pulse the set, go to IDLE.
  - Anything else: seq_err_o, and the current byte is re-evaluated as if in IDLE in the same cycle. The outputs of that re-evaluation are ORed with seq_err_o.
- LS1:
  - D 95 -> LS2. The 95 is consumed and not passed through.
  - Anything else: no error, since BC followed by idles is legal. The byte is re-evaluated as IDLE.
- LS2:
  - D B5, 4C or E8: store the byte, go to LS3.
  - Else: seq_err_o, re-evaluate the byte as IDLE.
- LS3:
  - Byte equals the stored byte with K=0: pulse SP, SPA or VER accordingly, go to IDLE.
  - Else: seq_err_o, re-evaluate as IDLE.
- Consumed bytes of an aborted sequence are discarded, never emitted on data_o.
- At most one multi-byte set completes per cycle. os_o may carry a multi-byte flag together with K/I only on re-evaluation paths, and those paths never complete a set, so effectively at most one set flag plus K/I is active per cycle.
- Reset mid-sequence: next cycle the FSM is in IDLE, the stored byte is cleared, and all pulses are 0. No error is reported for the abandoned sequence.

Decomposition:
- Add to aurora_pkg:
  - K/D character constants listed above
  - os_det_state_t enum (7 states)
  - OS_FLAG_COUNT = $bits(ordered_sets_t)
- One combinational sub-module, aurora_char_classify:
  - input byte + K flag
  - outputs one-hot class: single-set id, 2-byte start id, LS start, data, unknown K
  - used for both normal and re-evaluation paths.

Test Plan:
- Reset, then stream D 11,22,33 -> data_o 11,22,33 with data_valid_o on 3 consecutive cycles; os_o=0, no errors.
- BC,1C,7C,9C -> os_o K|I, R|I, A|I, P on 4 consecutive cycles (latency 1).
- 5C FB, FD FE, F7 F7 with rx_valid_i gaps of 3 idle cycles inside each pair -> SCP, ECP, CC each pulse once, 1 cycle after 2nd byte.
- BC 95 4C 4C -> K|I pulse, then SPA pulse after 4th byte, nothing in between; repeat with B5 (SP) and E8 (VER).
- BC 95 4C 4D(D) -> seq_err_o at 4th byte plus data_o=4D; 5C 1C -> seq_err_o together with R|I; lone FB -> code_err_o.
- BC 95 B5, assert rst one cycle, then B5 -> no SP; B5 emitted as data_o.
